// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared constants and types for the scoreboarded register file.
//   ADDRESS_WIDTH_DEF / DATA_WIDTH_DEF / NUM_READ_DEF / NUM_WRITE_DEF / DBG_REG_DEF :
//     default parameter values for regfile_sb.
//   reg_idx_t / reg_data_t : register index and register data types at default widths.
//   ZERO_REG : index of the hard-wired zero register.
package regfile_pkg;

  localparam int ADDRESS_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF    = 32;
  localparam int NUM_READ_DEF      = 2;
  localparam int NUM_WRITE_DEF     = 1;
  localparam int DBG_REG_DEF       = 10;

  typedef logic [ADDRESS_WIDTH_DEF-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH_DEF-1:0]    reg_data_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one busy bit per architectural register.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   rd_addr / rd_ready   : packed read indices; 1 = operand not pending
//   wr_en / wr_addr      : writeback strobes and indices (clear busy bits)
//   iss_valid / iss_rd   : issue request and the destination it reserves
//   iss_ready            : issue can be accepted this cycle
// Optional feature: REGFILE_BYPASS_EN -- a same-cycle writeback to a read index
// makes that read port ready, since the data is forwarded by the top level.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int NUM_READ      = NUM_READ_DEF,
  parameter int NUM_WRITE     = NUM_WRITE_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ-1:0]            rd_ready,
  input  logic [NUM_WRITE-1:0]           wr_en,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic                           iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]       iss_rd,
  output logic                           iss_ready
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [DEPTH-1:0] wb_clear;

  // Registers released by this cycle's writebacks; x0 is never tracked.
  always_comb begin
    wb_clear = '0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wr_en[w] && (wr_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] != ZERO_IDX)) begin
        wb_clear[wr_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b1;
      end
    end
  end

  // Depends only on state and writebacks, never on iss_valid.
  assign iss_ready = (iss_rd == ZERO_IDX) || !busy_reg[iss_rd] || wb_clear[iss_rd];

  // Clear first, then set, so an issue to a register being written back keeps it busy.
  always_comb begin
    busy_next = busy_reg & ~wb_clear;
    if (iss_valid && iss_ready && (iss_rd != ZERO_IDX)) begin
      busy_next[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd_ready
      logic [ADDRESS_WIDTH-1:0] addr;
      assign addr = rd_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
      assign rd_ready[gi] = (addr == ZERO_IDX) || !busy_reg[addr] || wb_clear[addr];
`else
      assign rd_ready[gi] = (addr == ZERO_IDX) || !busy_reg[addr];
`endif
    end
  endgenerate

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-ported register file with issue scoreboard.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   rd_addr / rd_data          : packed combinational read ports (x0 reads 0)
//   rd_ready                   : per read port, operand not pending
//   wr_en / wr_addr / wr_data  : writeback ports, higher port wins on conflicts
//   iss_valid / iss_rd         : issue request reserving destination iss_rd
//   iss_ready                  : issue accepted when iss_valid & iss_ready
//   dbg_data                   : committed contents of register DBG_REG
// Optional feature: REGFILE_BYPASS_EN -- reads forward same-cycle writeback data.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int NUM_READ      = NUM_READ_DEF,
  parameter int NUM_WRITE     = NUM_WRITE_DEF,
  parameter int DBG_REG       = DBG_REG_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]     rd_data,
  output logic [NUM_READ-1:0]                rd_ready,
  input  logic [NUM_WRITE-1:0]               wr_en,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]    wr_data,
  input  logic                              iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]          iss_rd,
  output logic                              iss_ready,
  output logic [DATA_WIDTH-1:0]             dbg_data
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO_REG);
  localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX  = ADDRESS_WIDTH'(DBG_REG);

  logic [DATA_WIDTH-1:0] regs_reg [DEPTH];

  // Ports are applied in ascending order, so the last non-blocking write
  // (highest port) wins when two ports target the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] != ZERO_IDX)) begin
          regs_reg[wr_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    data;
      assign addr = rd_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];

      always_comb begin
        data = regs_reg[addr];
`ifdef REGFILE_BYPASS_EN
        // Ascending scan gives the highest matching write port priority.
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (wr_en[w] && (wr_addr[w*ADDRESS_WIDTH +: ADDRESS_WIDTH] == addr)) begin
            data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
          end
        end
`endif
        // x0 overrides everything, including a forwarded write to x0.
        if (addr == ZERO_IDX) begin
          data = '0;
        end
      end

      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data;
    end
  endgenerate

  // Committed value only; writebacks in flight are not visible here.
  assign dbg_data = regs_reg[DBG_IDX];

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ),
    .NUM_WRITE     (NUM_WRITE)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- self-checking bench for regfile_sb (two read, two write ports).
// Directed table of vectors with hand-derived expectations, then randomized
// traffic compared against a register/busy-array reference model.
// Honors REGFILE_BYPASS_EN when defined for the build.
module tb_regfile_sb;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;
  localparam int DBG   = 10;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_ready;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic             iss_ready;
  logic [DW-1:0]    dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .NUM_READ      (NR),
    .NUM_WRITE     (NW),
    .DBG_REG       (DBG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .dbg_data  (dbg_data)
  );

  // ---------------- reference model ----------------
  bit [DW-1:0] m_regs [DEPTH];
  bit          m_busy [DEPTH];

  function automatic bit m_wb_hit(int a);
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] m_rd(int a);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    if (BYP)
      for (int w = 0; w < NW; w++)
        if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) v = wr_data[w*DW +: DW];
    return v;
  endfunction

  function automatic bit m_rdy(int a);
    if (a == 0) return 1'b1;
    if (BYP && m_wb_hit(a)) return 1'b1;
    return !m_busy[a];
  endfunction

  function automatic bit m_iss_ready();
    return (iss_rd == 0) || !m_busy[iss_rd] || m_wb_hit(int'(iss_rd));
  endfunction

  task automatic m_clock();
    bit acc;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      acc = iss_valid && m_iss_ready() && (iss_rd != 0);
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
          m_regs[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
          m_busy[wr_addr[w*AW +: AW]] = 1'b0;
        end
      end
      if (acc) m_busy[iss_rd] = 1'b1;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rd_addr = '0;
  endtask

  task automatic check_model(string tag);
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("%s.rd_data%0d", tag, p), rd_data[p*DW +: DW], m_rd(int'(rd_addr[p*AW +: AW])));
      chk($sformatf("%s.rd_ready%0d", tag, p), rd_ready[p], m_rdy(int'(rd_addr[p*AW +: AW])));
    end
    chk($sformatf("%s.iss_ready", tag), iss_ready, m_iss_ready());
    chk($sformatf("%s.dbg_data", tag), dbg_data, m_regs[DBG]);
  endtask

  function automatic logic [AW-1:0] pick();
    int r;
    if ($urandom_range(0, 7) == 0) return AW'($urandom);
    r = $urandom_range(0, 9);
    return (r == 9) ? AW'(DBG) : AW'(r);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    bit          iv;
    logic [4:0]  ir;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  erdy;
    bit          eiss;
    logic [31:0] edbg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, bit iv, logic [4:0] ir,
                              logic [4:0] ra0, logic [4:0] ra1, logic [31:0] e0, logic [31:0] e1,
                              logic [1:0] erdy, bit eiss, logic [31:0] edbg);
    vec_t v;
    v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.ir = ir; v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
    v.erdy = erdy; v.eiss = eiss; v.edbg = edbg;
    return v;
  endfunction

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    // Expectations are outputs seen with the row's inputs applied, before the clock edge.
    //                 rst we     wa0 wd0            wa1 wd1        iv ir  ra0 ra1 e0                    e1     erdy                 eiss edbg
    vecs.push_back(mk(0, 2'b11, 10, DB,             0,  32'h1234,  0, 0,  1,  0,  0,                    0,     2'b11,               1,   0));
    vecs.push_back(mk(0, 2'b00, 0,  0,              0,  0,         0, 0,  10, 0,  DB,                   0,     2'b11,               1,   DB));
    vecs.push_back(mk(0, 2'b00, 0,  0,              0,  0,         1, 5,  5,  10, 0,                    DB,    2'b11,               1,   DB));
    vecs.push_back(mk(0, 2'b00, 0,  0,              0,  0,         1, 5,  5,  0,  0,                    0,     2'b10,               0,   DB));
    vecs.push_back(mk(0, 2'b01, 5,  7,              0,  0,         0, 5,  10, 0,  DB,                   0,     2'b11,               1,   DB));
    vecs.push_back(mk(0, 2'b00, 0,  0,              0,  0,         0, 5,  5,  0,  7,                    0,     2'b11,               1,   DB));
    vecs.push_back(mk(0, 2'b11, 6,  9,              3,  32'h55,    1, 6,  7,  0,  0,                    0,     2'b11,               1,   DB));
    vecs.push_back(mk(0, 2'b00, 0,  0,              0,  0,         0, 6,  6,  0,  9,                    0,     2'b10,               0,   DB));
    vecs.push_back(mk(0, 2'b11, 3,  1,              3,  2,         0, 0,  3,  6,  BYP ? 32'd2 : 32'h55, 9,     2'b01,               1,   DB));
    vecs.push_back(mk(0, 2'b00, 0,  0,              0,  0,         0, 3,  3,  6,  2,                    9,     2'b01,               1,   DB));
    vecs.push_back(mk(0, 2'b01, 6,  32'hA,          0,  0,         0, 6,  6,  6,  BYP ? 32'hA : 32'd9,  BYP ? 32'hA : 32'd9, BYP ? 2'b11 : 2'b00, 1, DB));
    vecs.push_back(mk(0, 2'b01, 8,  5,              0,  0,         1, 7,  6,  7,  32'hA,                0,     2'b11,               1,   DB));
    vecs.push_back(mk(1, 2'b01, 9,  3,              0,  0,         1, 7,  8,  7,  5,                    0,     2'b01,               0,   DB));
    vecs.push_back(mk(0, 2'b00, 0,  0,              0,  0,         0, 7,  8,  9,  0,                    0,     2'b11,               1,   0));
  end

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state: every index reads zero and is ready.
    for (int i = 0; i < DEPTH / 2; i++) begin
      rd_addr = {AW'(2*i + 1), AW'(2*i)};
      #2;
      chk($sformatf("rst_rd%0d", 2*i),     rd_data[DW-1:0],  '0);
      chk($sformatf("rst_rd%0d", 2*i + 1), rd_data[2*DW-1:DW], '0);
      chk($sformatf("rst_rdy%0d", i),      rd_ready, 2'b11);
      chk($sformatf("rst_iss%0d", i),      iss_ready, 1'b1);
      chk($sformatf("rst_dbg%0d", i),      dbg_data, '0);
      $display("reset-read x%0d=%h x%0d=%h rdy=%b", 2*i, rd_data[DW-1:0], 2*i + 1, rd_data[2*DW-1:DW], rd_ready);
      tick();
    end

    // Directed table.
    foreach (vecs[k]) begin
      rst       = vecs[k].rst;
      wr_en     = vecs[k].we;
      wr_addr   = {vecs[k].wa1, vecs[k].wa0};
      wr_data   = {vecs[k].wd1, vecs[k].wd0};
      iss_valid = vecs[k].iv;
      iss_rd    = vecs[k].ir;
      rd_addr   = {vecs[k].ra1, vecs[k].ra0};
      #2;
      chk($sformatf("vec%0d.rd0", k),  rd_data[DW-1:0],    vecs[k].e0);
      chk($sformatf("vec%0d.rd1", k),  rd_data[2*DW-1:DW], vecs[k].e1);
      chk($sformatf("vec%0d.rdy", k),  rd_ready,           vecs[k].erdy);
      chk($sformatf("vec%0d.iss", k),  iss_ready,          vecs[k].eiss);
      chk($sformatf("vec%0d.dbg", k),  dbg_data,           vecs[k].edbg);
      $display("vec %0d rst=%b we=%b iss=%b/%0d rd=%h,%h rdy=%b iss_ready=%b dbg=%h",
               k, rst, wr_en, iss_valid, iss_rd, rd_data[DW-1:0], rd_data[2*DW-1:DW],
               rd_ready, iss_ready, dbg_data);
      tick();
    end
    idle_inputs();

    // Randomized traffic against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 300; t++) begin
      rst       = ($urandom_range(0, 49) == 0);
      wr_en     = NW'($urandom);
      wr_addr   = {pick(), pick()};
      wr_data   = {$urandom, $urandom};
      iss_valid = 1'($urandom);
      iss_rd    = pick();
      rd_addr   = {pick(), pick()};
      #2;
      check_model($sformatf("rnd%0d", t));
      $display("rnd %0d rst=%b we=%b wa=%h iss=%b/%0d ra=%h rd=%h rdy=%b iss_ready=%b",
               t, rst, wr_en, wr_addr, iss_valid, iss_rd, rd_addr, rd_data, rd_ready, iss_ready);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register index width; depth = 2**ADDRESS_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width.
REQ-003 SHALL have parameter NUM_READ, default 2, read-port count, legal 1..4.
REQ-004 SHALL have parameter NUM_WRITE, default 1, write-port count, legal 1..2.
REQ-005 SHALL have parameter DBG_REG, default 10, index of register driven onto dbg_data.
REQ-006 clk  input  1  single clock; all state changes on posedge clk.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 rd_addr  input  NUM_READ*ADDRESS_WIDTH  packed read indices, port p at slice p.
REQ-009 rd_data  output  NUM_READ*DATA_WIDTH  packed read data.
REQ-010 rd_ready  output  NUM_READ  1 = read operand not pending in scoreboard.
REQ-011 wr_en  input  NUM_WRITE  writeback strobe per write port.
REQ-012 wr_addr  input  NUM_WRITE*ADDRESS_WIDTH  writeback indices.
REQ-013 wr_data  input  NUM_WRITE*DATA_WIDTH  writeback data.
REQ-014 iss_valid  input  1  instruction issue request reserving destination iss_rd.
REQ-015 iss_rd  input  ADDRESS_WIDTH  destination index to mark busy.
REQ-016 iss_ready  output  1  issue accepted this cycle when iss_valid & iss_ready.
REQ-017 dbg_data  output  DATA_WIDTH  combinational view of register DBG_REG.

Function
REQ-018 Reads SHALL be combinational; index 0 SHALL always read 0 and report rd_ready=1.
REQ-019 Writes SHALL commit at posedge clk when wr_en set; writes to index 0 SHALL be discarded.
REQ-020 Two write ports with equal nonzero address in one cycle: port 1 data SHALL win.
REQ-021 Scoreboard: one busy bit per register; an accepted issue SHALL set busy[iss_rd] next cycle (ignored for iss_rd=0).
REQ-022 A writeback SHALL clear busy[wr_addr] next cycle.
REQ-023 Issue and writeback to same index in one cycle: busy SHALL end set (issue wins) and data SHALL still be written.
REQ-024 iss_ready SHALL be 0 while busy[iss_rd]=1 and no same-cycle writeback clears it; otherwise 1; iss_ready=1 for iss_rd=0.
REQ-025 rd_ready[p] SHALL be !busy[rd_addr[p]], subject to REQ-030.
REQ-026 iss_ready and rd_ready SHALL not depend on iss_valid (no combinational loop through issue).
REQ-027 dbg_data SHALL reflect committed contents of DBG_REG (no bypass).

Reset
REQ-028 While rst=1 at posedge clk: all registers SHALL clear to 0, all busy bits clear; issue and writes that cycle SHALL be ignored.
REQ-029 Outputs after reset: rd_data=0, rd_ready all 1, iss_ready=1, dbg_data=0.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: a read matching a same-cycle nonzero writeback SHALL return wr_data (REQ-020 priority) and rd_ready=1; undefined: read returns old contents and rd_ready follows busy bit only.

Structure
REQ-031 Package regfile_pkg SHALL hold default parameter constants, reg_idx_t/reg_data_t typedefs, and the zero-register index constant.
REQ-032 Scoreboard SHALL be sub-module regfile_scoreboard (busy bits, iss_ready, rd_ready); storage and bypass stay in regfile_sb.

Verification
REQ-033 Reset then read all 32 indices -> all 0, rd_ready all 1, dbg_data=0.
REQ-034 Write 0xDEADBEEF to x10, x0 <- 0x1234 -> next cycle rd x10=0xDEADBEEF, dbg_data=0xDEADBEEF, rd x0=0.
REQ-035 Issue rd=5, next cycle issue rd=5 -> iss_ready=0, rd_ready for x5=0; writeback x5=7 -> iss_ready=1 same cycle, busy clear next.
REQ-036 Same cycle issue x6 and writeback x6=9 -> x6 reads 9 next cycle, busy[6]=1.
REQ-037 NUM_WRITE=2, both ports write x3 (1, 2) -> x3=2; with REGFILE_BYPASS_EN same-cycle read x3 returns 2, without returns prior value.
REQ-038 Issue x7 and write x8=5, assert rst next cycle -> x8=0, busy[7]=0, iss_ready=1.
